// File: rtl/mcrc_pkg.sv
// Shared defaults, state encoding and width sanity helper for the framed
// MODBUS-style CRC engine.
package mcrc_pkg;

    localparam int unsigned MCRC_DWIDTH = 8;
    localparam int unsigned MCRC_CWIDTH = 16;

    localparam logic [MCRC_CWIDTH-1:0] MCRC_INITIAL = 16'hFFFF;
    localparam logic [MCRC_CWIDTH-1:0] MCRC_POLY    = 16'hA001;
    localparam logic [MCRC_CWIDTH-1:0] MCRC_RESIDUE = 16'h0000;

    typedef enum logic {
        PASS   = 1'b0,
        APPEND = 1'b1
    } state_t;

    // The CRC is emitted as whole data words, so it must split evenly.
    function automatic bit widths_ok(input int unsigned cwidth, input int unsigned dwidth);
        return (dwidth != 0) && (cwidth >= dwidth) && ((cwidth % dwidth) == 0);
    endfunction

endpackage

// File: rtl/mcrc_step.sv
// One full-word reflected CRC update: XOR the word in, then DWIDTH LSB-first
// shift/XOR iterations, all within one combinational cone.
module mcrc_step
    import mcrc_pkg::*;
#(
    parameter int unsigned        DWIDTH = MCRC_DWIDTH,
    parameter int unsigned        CWIDTH = MCRC_CWIDTH,
    parameter logic [CWIDTH-1:0]  POLY   = CWIDTH'(MCRC_POLY)
) (
    input  logic [CWIDTH-1:0] crc_in,
    input  logic [DWIDTH-1:0] data,
    output logic [CWIDTH-1:0] crc_out
);

    logic [CWIDTH-1:0] acc;

    // Loop bound is a parameter, so this unrolls into DWIDTH chained stages.
    always_comb begin
        acc = crc_in ^ CWIDTH'(data);
        for (int unsigned i = 0; i < DWIDTH; i++) begin
            acc = (acc >> 1) ^ (acc[0] ? POLY : '0);
        end
        crc_out = acc;
    end

endmodule

// File: rtl/mcrc_frame.sv
// Frame-aware CRC engine: generate mode appends the CRC (low word first),
// check mode passes the frame through and reports pass/fail at its end.
module mcrc_frame
    import mcrc_pkg::*;
#(
    parameter int unsigned        DWIDTH  = MCRC_DWIDTH,
    parameter int unsigned        CWIDTH  = MCRC_CWIDTH,
    parameter logic [CWIDTH-1:0]  INITIAL = CWIDTH'(MCRC_INITIAL),
    parameter logic [CWIDTH-1:0]  POLY    = CWIDTH'(MCRC_POLY),
    parameter logic [CWIDTH-1:0]  RESIDUE = CWIDTH'(MCRC_RESIDUE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    output logic [CWIDTH-1:0] crc,
    output logic              done,
    output logic              crc_ok,
    output logic              busy
);

    localparam int unsigned NWORDS = CWIDTH / DWIDTH;
    localparam int unsigned CNTW   = $clog2(NWORDS + 1);

    if (!widths_ok(CWIDTH, DWIDTH)) begin : g_bad_width
        $error("mcrc_frame: CWIDTH must be a non-zero multiple of DWIDTH");
    end

    state_t            state;
    state_t            state_next;
    logic [CWIDTH-1:0] crc_q;
    logic [CWIDTH-1:0] crc_base;
    logic [CWIDTH-1:0] crc_next;
    logic [CWIDTH-1:0] shreg;
    logic [CNTW-1:0]   cnt;
    logic              frame_mode;
    logic              eff_mode;
    logic              s_fire;
    logic              a_fire;
    logic              cnt_last;

    // Mode is only taken from the port on a frame's first beat.
    assign eff_mode = busy ? frame_mode : mode;
    assign crc_base = busy ? crc_q : INITIAL;
    assign cnt_last = (cnt == CNTW'(1));
    assign s_fire   = (state == PASS) && s_valid && m_ready;
    assign a_fire   = (state == APPEND) && m_ready;
    assign crc      = crc_q;

    mcrc_step #(
        .DWIDTH (DWIDTH),
        .CWIDTH (CWIDTH),
        .POLY   (POLY)
    ) u_step (
        .crc_in  (crc_base),
        .data    (s_data),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk) begin : fsm_state
        if (reset) begin
            state <= PASS;
        end else begin
            state <= state_next;
        end
    end

    // Zero-latency passthrough in PASS; APPEND drives the CRC words itself.
    always_comb begin : fsm_comb
        state_next = state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;
        case (state)
            PASS: begin
                s_ready = m_ready;
                m_valid = s_valid;
                m_data  = s_data;
                m_last  = eff_mode & s_last;
                if (s_valid && m_ready && s_last && !eff_mode) begin
                    state_next = APPEND;
                end
            end
            APPEND: begin
                m_valid = 1'b1;
                m_data  = shreg[DWIDTH-1:0];
                m_last  = cnt_last;
                if (m_ready && cnt_last) begin
                    state_next = PASS;
                end
            end
            default: state_next = PASS;
        endcase
    end

    always_ff @(posedge clk) begin : datapath
        if (reset) begin
            crc_q      <= INITIAL;
            shreg      <= '0;
            cnt        <= '0;
            frame_mode <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            crc_ok     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (s_fire) begin
                crc_q <= crc_next;
                busy  <= 1'b1;
                if (!busy) begin
                    frame_mode <= mode;
                end
                if (s_last) begin
                    if (eff_mode) begin
                        crc_ok <= (crc_next == RESIDUE);
                        done   <= 1'b1;
                        crc_q  <= INITIAL;
                        busy   <= 1'b0;
                    end else begin
                        shreg <= crc_next;
                        cnt   <= CNTW'(NWORDS);
                    end
                end
            end
            // Generated CRC always matches by construction, so crc_ok is set.
            if (a_fire) begin
                shreg <= shreg >> DWIDTH;
                cnt   <= cnt - CNTW'(1);
                if (cnt_last) begin
                    done   <= 1'b1;
                    crc_ok <= 1'b1;
                    crc_q  <= INITIAL;
                    busy   <= 1'b0;
                end
            end
        end
    end

endmodule
